// File: rtl/mips_pkg.sv
// Shared pipeline package: word widths and the memory arbiter state encoding.
package mips_pkg;

  localparam int WORD_W     = 32;
  localparam int INSTR_W    = 32;
  localparam int REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    IFETCH  = 2'b01,
    DACCESS = 2'b10
  } arb_state_t;

  // True while a memory transaction is in flight.
  function automatic logic arb_busy(arb_state_t s);
    return s != IDLE;
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates the fetch and memory stages onto one single-port memory.
// Data accesses win over fetches; a requester whose done flag is high is
// skipped for that cycle so a held request is not serviced twice.
module mem_arbiter
  import mips_pkg::*;
#(
  parameter int DATA_W = WORD_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ifReq,
  input  logic [DATA_W-1:0] ifAddr,
  input  logic              memReadM,
  input  logic              memWriteM,
  input  logic [DATA_W-1:0] dAddr,
  input  logic [DATA_W-1:0] dWdata,
  output logic [DATA_W-1:0] ifRdata,
  output logic [DATA_W-1:0] dRdata,
  output logic              ifDone,
  output logic              dDone,
  output logic              ifStall,
  output logic              dStall,
  output logic              memReq,
  output logic              memWe,
  output logic [DATA_W-1:0] memAddr,
  output logic [DATA_W-1:0] memWdata,
  input  logic [DATA_W-1:0] memRdata,
  input  logic              memReady
);

  arb_state_t        state_q, state_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              if_done_q, if_done_d;
  logic              d_done_q, d_done_d;
  logic              d_pending;
  logic              if_pending;

  // A requester counts as pending only if it was not just completed.
  always_comb begin
    d_pending  = (memReadM | memWriteM) & ~d_done_q;
    if_pending = ifReq & ~if_done_q;
  end

  // Next-state logic: grant from IDLE, complete on memReady, otherwise hold.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    we_d       = we_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    if_done_d  = 1'b0;
    d_done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (d_pending) begin
          state_d = DACCESS;
          addr_d  = dAddr;
          wdata_d = dWdata;
          we_d    = memWriteM;
        end else if (if_pending) begin
          state_d = IFETCH;
          addr_d  = ifAddr;
          wdata_d = '0;
          we_d    = 1'b0;
        end
      end
      IFETCH: begin
        if (memReady) begin
          if_rdata_d = memRdata;
          if_done_d  = 1'b1;
          state_d    = IDLE;
        end
      end
      DACCESS: begin
        if (memReady) begin
          if (!we_q) begin
            d_rdata_d = memRdata;
          end
          d_done_d = 1'b1;
          we_d     = 1'b0;
          state_d  = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        we_d    = 1'b0;
      end
    endcase
  end

  // State and captured-request registers, cleared asynchronously on reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
      if_done_q  <= 1'b0;
      d_done_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
      if_done_q  <= if_done_d;
      d_done_q   <= d_done_d;
    end
  end

  assign memReq   = arb_busy(state_q);
  assign memWe    = we_q;
  assign memAddr  = addr_q;
  assign memWdata = wdata_q;
  assign ifRdata  = if_rdata_q;
  assign dRdata   = d_rdata_q;
  assign ifDone   = if_done_q;
  assign dDone    = d_done_q;
  assign ifStall  = ifReq & ~if_done_q;
  assign dStall   = (memReadM | memWriteM) & ~d_done_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: requester tasks push expected results into queues,
// a memory responder models the RAM, and a monitor checks done pulses.
module tb_mem_arbiter;

  typedef struct {
    bit          isStore;
    logic [31:0] value;
  } dexp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ifReq = 1'b0;
  logic [31:0] ifAddr = '0;
  logic        memReadM = 1'b0;
  logic        memWriteM = 1'b0;
  logic [31:0] dAddr = '0;
  logic [31:0] dWdata = '0;
  logic [31:0] ifRdata;
  logic [31:0] dRdata;
  logic        ifDone;
  logic        dDone;
  logic        ifStall;
  logic        dStall;
  logic        memReq;
  logic        memWe;
  logic [31:0] memAddr;
  logic [31:0] memWdata;
  logic [31:0] memRdata = '0;
  logic        memReady = 1'b0;

  int checks = 0;
  int failures = 0;
  int cycleCnt = 0;
  int waitMode = 0;

  logic [31:0] ifExp[$];
  dexp_t       dExp[$];
  logic [31:0] lastLoadExp = '0;
  logic [31:0] dmem[logic [31:0]];
  logic [31:0] refMem[logic [31:0]];

  bit          ifActive = 0;
  bit          dataActive = 0;
  bit          dataStore = 0;
  logic [31:0] curIfAddr = '0;
  logic [31:0] curDAddr = '0;
  logic [31:0] curDWdata = '0;

  bit          inTxn = 0;
  int          waitLeft = 0;
  int          txnLen = 0;
  int          lastTxnLen = 0;
  int          txnCount = 0;
  logic        lastTxnWe = 1'b0;
  logic [31:0] startAddr = '0;
  logic [31:0] startWdata = '0;
  logic        startWe = 1'b0;
  logic [31:0] txnLog[$];
  int          lastIfDoneCycle = 0;
  int          lastDDoneCycle = 0;

  mem_arbiter #(.DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .ifReq(ifReq), .ifAddr(ifAddr),
    .memReadM(memReadM), .memWriteM(memWriteM), .dAddr(dAddr), .dWdata(dWdata),
    .ifRdata(ifRdata), .dRdata(dRdata), .ifDone(ifDone), .dDone(dDone),
    .ifStall(ifStall), .dStall(dStall),
    .memReq(memReq), .memWe(memWe), .memAddr(memAddr), .memWdata(memWdata),
    .memRdata(memRdata), .memReady(memReady)
  );

  // Free-running clock with a 10 ns period.
  always #5 clk = ~clk;

  // Cycle counter used to order completion events.
  always @(posedge clk) cycleCnt++;

  function automatic logic [31:0] instrWord(input logic [31:0] a);
    return a ^ 32'h2048_0005;
  endfunction

  function automatic logic [31:0] dataInit(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  function automatic void checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endfunction

  // Memory responder: counts transactions, checks request stability, answers after wait states.
  always @(posedge clk) begin
    #1;
    if (memReq === 1'b1) begin
      if (!inTxn) begin
        inTxn = 1;
        txnCount++;
        txnLog.push_back(memAddr);
        startAddr = memAddr;
        startWe = memWe;
        startWdata = memWdata;
        txnLen = 0;
        waitLeft = (waitMode < 0) ? int'($urandom_range(0, 3)) : waitMode;
        checkOutput("txnAddrLegal",
          32'((ifActive && memAddr == curIfAddr) || (dataActive && memAddr == curDAddr)), 32'd1);
        checkOutput("txnWe", 32'(memWe), 32'(dataActive && dataStore && memAddr == curDAddr));
        if (memWe) checkOutput("txnWdata", memWdata, curDWdata);
      end else begin
        checkOutput("holdAddr", memAddr, startAddr);
        checkOutput("holdWe", 32'(memWe), 32'(startWe));
        checkOutput("holdWdata", memWdata, startWdata);
      end
      txnLen++;
      if (waitLeft == 0) begin
        memReady = 1'b1;
        if (memAddr[31:28] == 4'h0) memRdata = instrWord(memAddr);
        else if (dmem.exists(memAddr)) memRdata = dmem[memAddr];
        else memRdata = dataInit(memAddr);
        if (memWe) dmem[memAddr] = memWdata;
        lastTxnLen = txnLen;
        lastTxnWe = memWe;
      end else begin
        memReady = 1'b0;
        memRdata = $urandom;
        waitLeft--;
      end
    end else begin
      inTxn = 0;
      memReady = 1'($urandom_range(0, 1));
      memRdata = $urandom;
    end
  end

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin : monitor
    logic [31:0] e;
    dexp_t de;
    if (!reset) begin
      if (!memReq) checkOutput("memWeIdle", 32'(memWe), 32'd0);
      if (ifDone) begin
        lastIfDoneCycle = cycleCnt;
        checkOutput("ifStallAtDone", 32'(ifStall), 32'd0);
        if (ifExp.size() == 0) begin
          checks++; failures++;
          $display("[TB] FAIL ifDoneUnexpected actual=pulse expected=none");
        end else begin
          e = ifExp.pop_front();
          checkOutput("ifRdata", ifRdata, e);
        end
      end
      if (dDone) begin
        lastDDoneCycle = cycleCnt;
        checkOutput("dStallAtDone", 32'(dStall), 32'd0);
        if (dExp.size() == 0) begin
          checks++; failures++;
          $display("[TB] FAIL dDoneUnexpected actual=pulse expected=none");
        end else begin
          de = dExp.pop_front();
          if (de.isStore) begin
            checkOutput("dRdataAfterStore", dRdata, lastLoadExp);
          end else begin
            checkOutput("dRdataLoad", dRdata, de.value);
            lastLoadExp = de.value;
          end
        end
      end
    end
  end

  // Fetch requester: hold ifReq through the done cycle, report latency in cycles.
  task automatic applyFetchStimulus(input logic [31:0] a, output int lat);
    @(posedge clk); #1;
    ifAddr = a; ifReq = 1'b1; curIfAddr = a; ifActive = 1;
    ifExp.push_back(instrWord(a));
    lat = -1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (ifDone) begin lat = k; break; end
      checkOutput("ifStallWait", 32'(ifStall), 32'd1);
    end
    if (lat < 0) begin
      checks++; failures++;
      $display("[TB] FAIL ifTimeout actual=no ifDone expected=ifDone within 200 cycles");
    end
    @(posedge clk); #1;
    ifReq = 1'b0; ifActive = 0; ifAddr = $urandom;
  endtask

  // Data requester: load or store, held through the done cycle.
  task automatic applyDataStimulus(input bit st, input logic [31:0] a, input logic [31:0] wd, output int lat);
    @(posedge clk); #1;
    dAddr = a; dWdata = wd; memWriteM = st;
    memReadM = st ? 1'($urandom_range(0, 1)) : 1'b1;
    curDAddr = a; curDWdata = wd; dataStore = st; dataActive = 1;
    if (st) begin
      refMem[a] = wd;
      dExp.push_back('{1'b1, 32'h0});
    end else begin
      dExp.push_back('{1'b0, refMem.exists(a) ? refMem[a] : dataInit(a)});
    end
    lat = -1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (dDone) begin lat = k; break; end
      checkOutput("dStallWait", 32'(dStall), 32'd1);
    end
    if (lat < 0) begin
      checks++; failures++;
      $display("[TB] FAIL dTimeout actual=no dDone expected=dDone within 200 cycles");
    end
    @(posedge clk); #1;
    memReadM = 1'b0; memWriteM = 1'b0; dataActive = 0; dWdata = $urandom;
  endtask

  // Watchdog so the run always ends.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog actual=running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenarios followed by a randomized two-requester phase.
  initial begin
    int lat, lat2, t0;
    repeat (2) @(posedge clk);
    #2;
    checkOutput("rstMemReq", 32'(memReq), 32'd0);
    checkOutput("rstMemWe", 32'(memWe), 32'd0);
    checkOutput("rstMemAddr", memAddr, 32'd0);
    checkOutput("rstMemWdata", memWdata, 32'd0);
    checkOutput("rstIfRdata", ifRdata, 32'd0);
    checkOutput("rstDRdata", dRdata, 32'd0);
    checkOutput("rstIfDone", 32'(ifDone), 32'd0);
    checkOutput("rstDDone", 32'(dDone), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    $display("[TB] minimum-latency fetch");
    waitMode = 0;
    t0 = txnCount;
    applyFetchStimulus(32'h0040_0000, lat);
    checkOutput("fetchLatency", 32'(lat), 32'd2);
    checkOutput("fetchMemReqCycles", 32'(lastTxnLen), 32'd1);
    checkOutput("fetchWord", ifRdata, 32'h2008_0005);
    repeat (3) @(posedge clk);
    checkOutput("noRegrant", 32'(txnCount - t0), 32'd1);

    $display("[TB] simultaneous fetch and load");
    waitMode = 1;
    txnLog.delete();
    fork
      applyFetchStimulus(32'h0040_0004, lat);
      applyDataStimulus(1'b0, 32'h1001_0000, 32'h0, lat2);
    join
    checkOutput("prioFirst", (txnLog.size() > 0) ? txnLog[0] : 32'hFFFF_FFFF, 32'h1001_0000);
    checkOutput("prioSecond", (txnLog.size() > 1) ? txnLog[1] : 32'hFFFF_FFFF, 32'h0040_0004);
    checkOutput("dDoneBeforeIfDone", 32'(lastDDoneCycle < lastIfDoneCycle), 32'd1);

    $display("[TB] store with three wait states");
    waitMode = 3;
    applyDataStimulus(1'b1, 32'h1001_0004, 32'hDEAD_BEEF, lat);
    checkOutput("storeMemReqCycles", 32'(lastTxnLen), 32'd4);
    checkOutput("storeWe", 32'(lastTxnWe), 32'd1);
    checkOutput("storeLatency", 32'(lat), 32'd5);
    waitMode = 0;
    applyDataStimulus(1'b0, 32'h1001_0004, 32'h0, lat);

    $display("[TB] randomized traffic");
    waitMode = -1;
    fork
      begin : fetchLoop
        int fl;
        for (int i = 0; i < 30; i++) begin
          repeat ($urandom_range(0, 3)) @(posedge clk);
          applyFetchStimulus(32'h0040_0000 + ($urandom_range(0, 63) << 2), fl);
        end
      end
      begin : dataLoop
        int dl;
        for (int i = 0; i < 30; i++) begin
          repeat ($urandom_range(0, 3)) @(posedge clk);
          applyDataStimulus(1'($urandom_range(0, 1)), 32'h1001_0000 + ($urandom_range(0, 7) << 2),
                            $urandom, dl);
        end
      end
    join

    $display("[TB] reset during data access");
    waitMode = 30;
    @(posedge clk); #1;
    memReadM = 1'b1; memWriteM = 1'b0; dAddr = 32'h1001_0008;
    curDAddr = 32'h1001_0008; dataStore = 0; dataActive = 1;
    ifReq = 1'b1; ifAddr = 32'h0040_0010; curIfAddr = 32'h0040_0010; ifActive = 1;
    repeat (3) @(negedge clk);
    checkOutput("dAccessBusy", 32'(memReq), 32'd1);
    checkOutput("dAccessAddr", memAddr, 32'h1001_0008);
    #2;
    reset = 1'b1;
    waitMode = 0;
    #1;
    checkOutput("asyncMemReq", 32'(memReq), 32'd0);
    checkOutput("asyncMemAddr", memAddr, 32'd0);
    checkOutput("asyncDRdata", dRdata, 32'd0);
    checkOutput("asyncIfRdata", ifRdata, 32'd0);
    checkOutput("asyncDDone", 32'(dDone), 32'd0);
    lastLoadExp = '0;
    memReadM = 1'b0; dataActive = 0;
    repeat (2) @(posedge clk); #1;
    reset = 1'b0;
    ifExp.push_back(instrWord(32'h0040_0010));
    @(negedge clk);
    checkOutput("noGrantAtRelease", 32'(memReq), 32'd0);
    @(negedge clk);
    checkOutput("grantAfterRelease", 32'(memReq), 32'd1);
    checkOutput("grantAfterReleaseAddr", memAddr, 32'h0040_0010);
    lat = -1;
    for (int k = 0; k < 20; k++) begin
      if (ifDone) begin lat = k; break; end
      @(negedge clk);
    end
    if (lat < 0) begin
      checks++; failures++;
      $display("[TB] FAIL postResetFetchTimeout actual=no ifDone expected=ifDone");
    end
    @(posedge clk); #1;
    ifReq = 1'b0; ifActive = 0;

    repeat (5) @(posedge clk);
    checkOutput("ifQueueEmpty", 32'(ifExp.size()), 32'd0);
    checkOutput("dQueueEmpty", 32'(dExp.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: DATA_W, 32, width of address and data buses.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 ifReq  input  1  fetch-stage read request; held until ifDone.
REQ-005 ifAddr  input  DATA_W  fetch address; stable while ifReq is high.
REQ-006 memReadM  input  1  memory-stage load request.
REQ-007 memWriteM  input  1  memory-stage store request.
REQ-008 dAddr  input  DATA_W  data address; stable while the request is high.
REQ-009 dWdata  input  DATA_W  store data.
REQ-010 ifRdata  output  DATA_W  registered instruction word.
REQ-011 dRdata  output  DATA_W  registered load data.
REQ-012 ifDone, dDone  output  1 each  one-cycle completion pulses.
REQ-013 ifStall, dStall  output  1 each  stall requests, ORed by the pipeline into stallF and stallD/stallM.
REQ-014 memReq, memWe  output  1 each  shared single-port memory request and write enable.
REQ-015 memAddr, memWdata  output  DATA_W each  shared memory address and write data.
REQ-016 memRdata  input  DATA_W  memory read data; valid when memReady is high.
REQ-017 memReady  input  1  memory completion; may take any number of wait cycles.

Function
REQ-018 FSM states shall be IDLE, IFETCH and DACCESS; at most one memory transaction is outstanding.
REQ-019 In IDLE, a data request is pending when (memReadM|memWriteM) is high and dDone is low; it moves the FSM to DACCESS.
- A data request has priority over a fetch.
REQ-020 In IDLE with no pending data request, a fetch is pending when ifReq is high and ifDone is low; it moves the FSM to IFETCH.
- Otherwise the FSM stays in IDLE.
REQ-021 On grant, the address, write data and write flag shall be captured into registers.
- memAddr, memWdata and memWe are driven only from these registers.
- memReq is high exactly while the FSM is in IFETCH or DACCESS.
REQ-022 memWe shall be high only in DACCESS, and only for a store.
- If memReadM and memWriteM are both high, the access is a store.
REQ-023 In IFETCH or DACCESS, a cycle with memReady high shall complete the transaction:
- memRdata is latched into ifRdata or dRdata (dRdata is unchanged for a store);
- the matching done flag is set for exactly the next cycle;
- the FSM returns to IDLE.
REQ-024 A cycle with memReady low in a busy state shall hold all registered outputs; any number of wait states is legal.
REQ-025 ifStall = ifReq & ~ifDone, and dStall = (memReadM|memWriteM) & ~dDone, both combinational.
REQ-026 Minimum latency shall be 2 cycles: request at cycle N, memReq at N+1, memReady at N+1, done and stall low at N+2.
REQ-027 A requester whose done flag is high shall not be re-granted in that cycle; the other requester may be granted in that cycle.
REQ-028 memReady asserted while in IDLE shall be ignored.
REQ-029 A request dropped mid-transaction shall not abort the memory access.
- The access completes and its done pulse is still issued.
- The requester is responsible for ignoring that pulse.

Reset
REQ-030 On reset, all of the following shall be forced asynchronously, with no edge required: FSM = IDLE; memReq = 0; memWe = 0; memAddr = 0; memWdata = 0; ifRdata = 0; dRdata = 0; ifDone = 0; dDone = 0.
REQ-031 Reset asserted mid-transaction shall abandon the access without a done pulse.
- The first grant occurs in the first cycle after reset deasserts.

Structure
REQ-032 The FSM state encoding shall live in the shared package mips_pkg, alongside the existing pipeline width constants:
- IDLE = 2'b00;
- IFETCH = 2'b01;
- DACCESS = 2'b10.
REQ-033 The block shall be a single module with no sub-module; it is instantiated beside the hazard unit, and its stall outputs are ORed with the hazard unit's stalls at the top level.

Verification
REQ-034 Fetch 0x00400000, memReady at the first memReq cycle, memRdata 0x20080005 -> memReq high 1 cycle; ifRdata = 0x20080005 and ifDone pulse at cycle 2; ifStall low at cycle 2.
REQ-035 ifReq and memReadM asserted together (dAddr 0x10010000) -> DACCESS first; dDone before IFETCH starts; ifStall held high through both transactions.
REQ-036 Store dAddr 0x10010004, dWdata 0xDEADBEEF, 3 wait states -> memWe=1 and data stable for 4 cycles; dRdata unchanged; single dDone pulse.
REQ-037 Requests held high through their done cycle -> no duplicate grant; the next transaction starts only after a new request or the other requester.
REQ-038 Reset asserted during DACCESS with memReady low -> memReq=0 immediately; no dDone; fetch granted the cycle after reset release.
